// File: rtl/fifo_byte_drain_pkg.sv
// fifo_byte_drain_pkg: FSM encoding and helpers shared by the FIFO byte drain
package fifo_byte_drain_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_EMIT = 2'd2} state_t;
  localparam int DEF_COUNT_WIDTH = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_byte_drain.sv
// fifo_byte_drain: pops words from a non-fallthrough FIFO and serializes them into a byte stream
module fifo_byte_drain
  import fifo_byte_drain_pkg::*;
#(
  parameter int pDATA_WIDTH  = 64,
  parameter bit pMSB_FIRST   = 1'b0,
  parameter int pCOUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    fifo_empty,
  input  logic                    fifo_underflow,
  output logic                    fifo_ren,
  input  logic [pDATA_WIDTH-1:0]  fifo_rdata,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic                    byte_last,
  output logic [pCOUNT_WIDTH-1:0] words_read,
  output logic                    error
);
  localparam int P_BYTES = pDATA_WIDTH / 8;
  localparam int P_IDX_W = clog2(P_BYTES) < 1 ? 1 : clog2(P_BYTES);
  state_t                  r_state, w_next;
  logic [pDATA_WIDTH-1:0]  r_shift;
  logic [P_IDX_W-1:0]      r_idx;
  logic [pCOUNT_WIDTH-1:0] r_words;
  logic                    r_error;
  logic                    w_can_pop, w_last, w_hs;
  always_comb begin
    w_can_pop  = enable && !fifo_empty && !flush && !reset;
    w_last     = r_idx == P_IDX_W'(P_BYTES - 1);
    byte_valid = r_state == S_EMIT;
    w_hs       = byte_valid && byte_ready;
    byte_last  = byte_valid && w_last;
    fifo_ren   = w_can_pop && (r_state == S_IDLE || (w_hs && w_last));
    byte_data  = pMSB_FIRST ? r_shift[pDATA_WIDTH-1 -: 8] : r_shift[7:0];
    w_next     = S_IDLE;
    if (!flush)
      w_next = r_state == S_IDLE ? (fifo_ren ? S_LOAD : S_IDLE) :
               r_state == S_LOAD ? S_EMIT :
               (r_state == S_EMIT && !(w_hs && w_last)) ? S_EMIT :
               fifo_ren ? S_LOAD : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_words <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        r_shift <= fifo_rdata;
        r_idx   <= '0;
      end else if (w_hs && !w_last) begin
        r_shift <= pMSB_FIRST ? r_shift << 8 : r_shift >> 8;
        r_idx   <= r_idx + 1'b1;
      end
      if (fifo_ren) r_words <= r_words + 1'b1;
      // flush wins over a coincident underflow pulse
      r_error <= flush ? 1'b0 : (fifo_underflow | r_error);
    end
  end
  assign words_read = r_words;
  assign error      = r_error;
endmodule

// File: doc/fifo_byte_drain.md
# fifo_byte_drain

Downstream read-side stage for the synchronous capture FIFO (non-fallthrough mode, one-cycle read latency). It pops `pDATA_WIDTH`-bit words from the FIFO and serializes each word into bytes on a valid/ready stream toward the USB readout path. It also keeps a popped-word counter and a sticky underflow error.

## Interface
Parameters:
- `pDATA_WIDTH`, default 64: FIFO word width. Must be a multiple of 8, range 8–128.
- `pMSB_FIRST`, default 0: 0 emits `[7:0]` first; 1 emits the top byte first.
- `pCOUNT_WIDTH`, default 16: width of `words_read`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits new FIFO pops.
- `flush` in 1: synchronous abort of the current word.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_underflow` in 1: FIFO underflow pulse.
- `fifo_ren` out 1: FIFO read strobe (combinational from state).
- `fifo_rdata` in `pDATA_WIDTH`: FIFO registered read data.
- `byte_valid` out 1: output byte valid.
- `byte_ready` in 1: consumer accepts the byte.
- `byte_data` out 8: output byte.
- `byte_last` out 1: marks the final byte of a word.
- `words_read` out `pCOUNT_WIDTH`: count of FIFO pops.
- `error` out 1: sticky; set by underflow.

## Operation
- Localparam `pBYTES = pDATA_WIDTH/8`. Byte index counter is `clog2(pBYTES)` bits, minimum 1.
- FSM states:
  - IDLE: if `enable && !fifo_empty && !flush`, assert `fifo_ren` and go to LOAD.
  - LOAD: capture `fifo_rdata` into the shift register, clear the byte index, go to EMIT.
  - EMIT: `byte_valid=1`. On `byte_valid && byte_ready`:
    - Not the last byte: advance the index (shift by 8).
    - Last byte: if `enable && !fifo_empty && !flush`, assert `fifo_ren` this cycle and go to LOAD. Otherwise go to IDLE.
- `fifo_ren` is asserted only in the two cases above. It is never asserted while `fifo_empty=1`, so the block never causes an underflow itself.
- `byte_data` is the current byte, selected by `pMSB_FIRST`.
- `byte_last = byte_valid && (index == pBYTES-1)`. For `pBYTES==1`, `byte_last` equals `byte_valid`.
- `words_read` increments on every cycle with `fifo_ren=1` and wraps at 2^`pCOUNT_WIDTH`. It is cleared only by `reset`.
- `error`:
  - Set on any cycle with `fifo_underflow=1`.
  - Cleared by `reset` or `flush`. `flush` has priority when both occur in the same cycle.
- Deasserting `enable` mid-word does not abort. The current word completes, and no new pop follows.

## Timing
- Reset values: FSM=IDLE; `byte_valid`, `byte_last`, `fifo_ren`, `error`, `words_read` all 0; `byte_data` 0.
- Latency: `fifo_ren` in cycle t → LOAD in t+1 → first `byte_valid` in t+2.
- Throughput: `pBYTES`+1 cycles per word with `byte_ready` held high. There is one LOAD bubble per word.
- Handshake: while `byte_valid && !byte_ready`, `byte_data` and `byte_last` hold stable. `byte_valid` never drops without a handshake, except on `flush` or `reset`.
- `flush` in any state:
  - Next state is IDLE, and `byte_valid` is 0 from the next cycle.
  - No `fifo_ren` is asserted in the flush cycle.
  - A word already popped (LOAD or EMIT) is discarded; `words_read` still counts it.
- `reset` mid-word has the same effect as `flush`, and additionally clears `words_read`.
- `fifo_empty` rising during EMIT has no effect until the last byte.

## Structure
- Shared package holds:
  - The FSM state encoding (IDLE/LOAD/EMIT, 2 bits).
  - The `clog2` function.
  - The default `pCOUNT_WIDTH`.
- No sub-module is needed; a single flat module holds the FSM, shift register, index counter, and word counter.
- The bench instantiates this block with `fifo_sync` configured `pFALLTHROUGH=0`.

## Test plan
- **Single word, LSB-first.** Write 0x0807060504030201, `enable=1`, `byte_ready=1` → bytes 01..08 on consecutive cycles starting 2 cycles after `fifo_ren`; `byte_last` on 08; `words_read=1`.
- **Back-to-back words, MSB-first.** `pMSB_FIRST=1`, two words in the FIFO → each word emitted MSB-first; exactly one idle cycle between words (18 cycles total); `fifo_ren` coincides with the last-byte handshake; `words_read=2`.
- **Backpressure.** Drop `byte_ready` for 5 cycles on byte 3 → `byte_data`=03 held stable; remaining bytes in order; no extra `fifo_ren`.
- **Flush mid-word.** Assert `flush` at byte 4 → `byte_valid`=0 next cycle; FSM IDLE; that word is lost; the next word restarts at byte 0; `error` cleared.
- **Empty/enable gating.** FIFO empty with `enable=1` → `fifo_ren` never asserted, no underflow. `enable` dropped mid-word → the word completes and no further pop occurs despite a non-empty FIFO.
- **Counter wrap and error.** With `pCOUNT_WIDTH=4`, 17 pops → `words_read=1`. An external `fifo_underflow` pulse sets `error`, which stays 1 until `flush`.
